// File: rtl/front_layer_ctrl.sv
// rtl/front_layer_ctrl.sv - conv1 front-layer sequencer: weight load, 28x28 compute sweep, pipeline drain
// Optional pass cycle counter enabled by macro FRONT_CTRL_PERF_EN.
module front_layer_ctrl #(
  parameter int W_LOAD_CYC = 158,
  parameter int OUT_DIM    = 28,
  parameter int PIPE_LAT   = 3,
  parameter int OFM_AW     = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_ofm_full,
  output logic [4:0]        o_st,
  output logic [4:0]        o_in_cell_row,
  output logic [4:0]        o_in_cell_col,
  output logic              o_calc_en,
  output logic              o_ofm_we,
  output logic [OFM_AW-1:0] o_ofm_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_perf_cycles
);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_LOAD_W = 5'b00010,
    S_CALC   = 5'b00100,
    S_DONE   = 5'b01000
  } state_t;

  localparam int LCW = $clog2(W_LOAD_CYC + 1);

  state_t                         r_st;
  logic [4:0]                     r_row;
  logic [4:0]                     r_col;
  logic [LCW-1:0]                 r_load_cnt;
  logic [2:0]                     r_drain_cnt;
  logic [PIPE_LAT-1:0]            r_dly_v;
  logic [PIPE_LAT-1:0][OFM_AW-1:0] r_dly_a;

  logic              w_compute;
  logic              w_calc_en;
  logic [OFM_AW-1:0] w_pix_addr;

  // Row OUT_DIM marks the drain phase; only rows below it issue pixels.
  assign w_compute  = (r_st == S_CALC) && (r_row < 5'(OUT_DIM));
  assign w_calc_en  = w_compute && !i_ofm_full;
  assign w_pix_addr = OFM_AW'(r_row) * OFM_AW'(OUT_DIM) + OFM_AW'(r_col);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st        <= S_IDLE;
      r_row       <= 5'd0;
      r_col       <= 5'd0;
      r_load_cnt  <= '0;
      r_drain_cnt <= 3'd0;
    end else begin
      case (r_st)
        S_IDLE: begin
          r_row       <= 5'd0;
          r_col       <= 5'd0;
          r_load_cnt  <= '0;
          r_drain_cnt <= 3'd0;
          if (i_start) r_st <= S_LOAD_W;
        end
        S_LOAD_W: begin
          if (r_load_cnt == LCW'(W_LOAD_CYC - 1)) begin
            r_load_cnt <= '0;
            r_st       <= S_CALC;
          end else begin
            r_load_cnt <= r_load_cnt + 1'b1;
          end
        end
        S_CALC: begin
          if (!i_ofm_full) begin
            if (r_row < 5'(OUT_DIM)) begin
              if (r_col == 5'(OUT_DIM - 1)) begin
                r_col <= 5'd0;
                r_row <= r_row + 5'd1;
              end else begin
                r_col <= r_col + 5'd1;
              end
            end else if (r_drain_cnt == 3'(PIPE_LAT - 1)) begin
              r_drain_cnt <= 3'd0;
              r_row       <= 5'd0;
              r_st        <= S_DONE;
            end else begin
              r_drain_cnt <= r_drain_cnt + 3'd1;
            end
          end
        end
        S_DONE: r_st <= S_IDLE;
        default: begin
          r_st        <= S_IDLE;
          r_row       <= 5'd0;
          r_col       <= 5'd0;
          r_load_cnt  <= '0;
          r_drain_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Delay line mirrors the MAC latency and freezes with the datapath on back-pressure.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dly_v <= '0;
      r_dly_a <= '0;
    end else if (!i_ofm_full) begin
      r_dly_v[0] <= w_calc_en;
      r_dly_a[0] <= w_pix_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_dly_v[i] <= r_dly_v[i-1];
        r_dly_a[i] <= r_dly_a[i-1];
      end
    end
  end

`ifdef FRONT_CTRL_PERF_EN
  logic [15:0] r_perf;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf <= 16'h0000;
    end else if (r_st == S_IDLE && i_start) begin
      r_perf <= 16'h0000;
    end else if ((r_st == S_LOAD_W || r_st == S_CALC) && r_perf != 16'hFFFF) begin
      r_perf <= r_perf + 16'h0001;
    end
  end
  assign o_perf_cycles = r_perf;
`else
  assign o_perf_cycles = 16'h0000;
`endif

  assign o_st          = r_st;
  assign o_in_cell_row = r_row;
  assign o_in_cell_col = r_col;
  assign o_calc_en     = w_calc_en;
  assign o_ofm_we      = r_dly_v[PIPE_LAT-1] && !i_ofm_full;
  assign o_ofm_addr    = r_dly_a[PIPE_LAT-1];
  assign o_busy        = (r_st != S_IDLE);
  assign o_done        = (r_st == S_DONE);

endmodule

// File: tb/tb_front_layer_ctrl.sv
// tb/tb_front_layer_ctrl.sv - self-checking bench for front_layer_ctrl (vector table + address scoreboard)
module tb_front_layer_ctrl;
  localparam int PIPE_LAT = 3;
  localparam int OFM_AW   = 10;
  localparam logic [4:0] ST_IDLE = 5'b00001, ST_LOAD = 5'b00010, ST_CALC = 5'b00100, ST_DONE = 5'b01000;

  logic clk = 1'b0;
  logic rst, start, ofm_full;
  logic [4:0] st, row, col;
  logic calc_en, ofm_we, busy, done;
  logic [OFM_AW-1:0] ofm_addr;
  logic [15:0] perf;

  front_layer_ctrl #(.W_LOAD_CYC(158), .OUT_DIM(28), .PIPE_LAT(PIPE_LAT), .OFM_AW(OFM_AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ofm_full(ofm_full),
    .o_st(st), .o_in_cell_row(row), .o_in_cell_col(col), .o_calc_en(calc_en),
    .o_ofm_we(ofm_we), .o_ofm_addr(ofm_addr), .o_busy(busy), .o_done(done),
    .o_perf_cycles(perf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];

  // stall_row -1: no stall; -2: stall in LOAD_W at cycle stall_col; else stall at (row,col)
  typedef struct {
    int stall_row;
    int stall_col;
    int stall_len;
    bit hold_start;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_st"}, int'(st), int'(ST_IDLE));
    check({tag, "_row"}, int'(row), 0);
    check({tag, "_col"}, int'(col), 0);
    check({tag, "_calc_en"}, int'(calc_en), 0);
    check({tag, "_ofm_we"}, int'(ofm_we), 0);
    check({tag, "_ofm_addr"}, int'(ofm_addr), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_perf"}, int'(perf), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; ofm_full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int exp_done, delay, we_cnt, drain_cnt, stall_left, hold_r, hold_c, exp_perf;
    bit stall_done, trig;
    logic [4:0] exp_st;
    delay    = (v.stall_row == -2) ? 0 : v.stall_len;
    exp_done = 946 + delay;
`ifdef FRONT_CTRL_PERF_EN
    exp_perf = exp_done - 1;
`else
    exp_perf = 0;
`endif
    q.delete();
    for (int i = 0; i < 784; i++) q.push_back(i);
    we_cnt = 0; drain_cnt = 0; stall_left = 0; stall_done = 1'b0; hold_r = 0; hold_c = 0;
    @(posedge clk); #1;
    start = 1'b1;
    for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
      @(posedge clk); #1;
      if (!v.hold_start) start = 1'b0;
      if (v.stall_row == -2) trig = (st == ST_LOAD) && (cyc == v.stall_col);
      else trig = (st == ST_CALC) && (int'(row) == v.stall_row) && (int'(col) == v.stall_col);
      if (!stall_done && v.stall_len > 0 && trig) begin
        stall_left = v.stall_len;
        stall_done = 1'b1;
        hold_r = int'(row);
        hold_c = int'(col);
      end
      ofm_full = (stall_left > 0);
      #1;
      if (cyc <= 158) exp_st = ST_LOAD;
      else if (cyc < exp_done) exp_st = ST_CALC;
      else if (cyc == exp_done) exp_st = ST_DONE;
      else if (v.hold_start && cyc == exp_done + 2) exp_st = ST_LOAD;
      else exp_st = ST_IDLE;
      check("st", int'(st), int'(exp_st));
      check("done", int'(done), int'(cyc == exp_done));
      check("busy", int'(busy), int'(exp_st != ST_IDLE));
      if (ofm_we) begin
        we_cnt++;
        if (q.size() == 0) check("extra_ofm_we", 1, 0);
        else check("ofm_addr", int'(ofm_addr), q.pop_front());
      end
      if (st == ST_CALC && row == 5'd28) begin
        drain_cnt++;
        check("drain_calc_en", int'(calc_en), 0);
      end
      if (stall_left > 0) begin
        check("stall_ofm_we", int'(ofm_we), 0);
        check("stall_calc_en", int'(calc_en), 0);
        if (v.stall_row != -2) begin
          check("stall_row_hold", int'(row), hold_r);
          check("stall_col_hold", int'(col), hold_c);
        end
        stall_left--;
      end
      if (cyc == exp_done + 1) check("perf_cycles", int'(perf), exp_perf);
    end
    ofm_full = 1'b0;
    start = 1'b0;
    check("we_count", we_cnt, 784);
    check("sb_left", q.size(), 0);
    check("drain_cycles", drain_cnt, PIPE_LAT + ((v.stall_row == 28) ? v.stall_len : 0));
    if (v.hold_start) do_reset();
  endtask

  initial begin
    int guard;
    vecs[0] = '{-1, 0, 0, 1'b0};
    vecs[1] = '{3, 5, 10, 1'b0};
    vecs[2] = '{-1, 0, 0, 1'b1};
    vecs[3] = '{-2, 50, 6, 1'b0};
    vecs[4] = '{28, 0, 4, 1'b0};
    vecs[5] = '{0, 0, 1, 1'b0};

    rst = 1'b1; start = 1'b0; ofm_full = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; #1;
    check_idle_zero("reset");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort mid-CALCULATION at row 12: immediate IDLE, no done, then a clean pass.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(st == ST_CALC && row == 5'd12) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_row12", int'(guard < 2000), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_idle_zero("abort");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("abort_no_done", int'(done), 0);
      check("abort_st", int'(st), int'(ST_IDLE));
    end
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
